// File: rtl/mp_add_sequencer.sv
// Word-serial multi-precision add sequencer: feeds an external DATA_WID-bit adder LSW-first and chains carries word to word.
// Optional subtract mode (InSub port, A-B with borrow chain) is enabled by defining MPADD_SUB_EN.
module mp_add_sequencer #(
    parameter int DATA_WID  = 64,
    parameter int MAX_WORDS = 16
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                InValid,
    output logic                InReady,
    input  logic [DATA_WID-1:0] InA,
    input  logic [DATA_WID-1:0] InB,
    input  logic                InFirst,
    input  logic                InLast,
    input  logic                InCarry,
`ifdef MPADD_SUB_EN
    input  logic                InSub,
`endif
    output logic [DATA_WID-1:0] AdderA,
    output logic [DATA_WID-1:0] AdderB,
    output logic                AdderCin,
    input  logic [DATA_WID-1:0] AdderSum,
    input  logic                AdderCout,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [DATA_WID-1:0] OutSum,
    output logic                OutFirst,
    output logic                OutLast,
    output logic                OutCarry,
    output logic                ErrOverrun
);

    localparam int            CW      = $clog2(MAX_WORDS) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state;
    logic [CW-1:0]         word_cnt;

    logic                  s1_vld;
    logic [DATA_WID-1:0]   s1_a;
    logic [DATA_WID-1:0]   s1_b;
    logic                  s1_first;
    logic                  s1_last;
    logic                  s1_cin;
    logic                  c_reg;

    logic                  adv1;
    logic                  accept;
    logic                  eff_first;
    logic [CW-1:0]         next_cnt;
    logic                  force_last;
    logic                  end_pkt;

    assign adv1       = s1_vld && (!OutValid || OutReady);
    assign InReady    = !s1_vld || adv1;
    assign accept     = InValid && InReady;

    // A beat arriving while idle always opens a packet, even without InFirst.
    assign eff_first  = InFirst || (state == IDLE);
    assign next_cnt   = eff_first ? CW'(1) : word_cnt + CW'(1);
    assign force_last = !InLast && (next_cnt == MAX_CNT);
    assign end_pkt    = InLast || force_last;

    assign AdderA     = s1_a;
    assign AdderCin   = s1_first ? s1_cin : c_reg;

`ifdef MPADD_SUB_EN
    logic s1_sub;
    logic pkt_sub;
    logic sub_now;

    assign sub_now = eff_first ? InSub : pkt_sub;
    assign AdderB  = s1_sub ? ~s1_b : s1_b;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_sub  <= 1'b0;
            pkt_sub <= 1'b0;
        end else if (accept) begin
            s1_sub  <= sub_now;
            pkt_sub <= sub_now;
        end
    end
`else
    assign AdderB = s1_b;
`endif

    // Packet framing: word counter, overrun detection
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            word_cnt   <= '0;
            ErrOverrun <= 1'b0;
        end else begin
            ErrOverrun <= 1'b0;
            if (accept) begin
                ErrOverrun <= force_last;
                if (end_pkt) begin
                    state    <= IDLE;
                    word_cnt <= '0;
                end else begin
                    state    <= ACTIVE;
                    word_cnt <= next_cnt;
                end
            end
        end
    end

    // Stage 1: operand register driving the adder
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_vld   <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_cin   <= 1'b0;
        end else if (accept) begin
            s1_vld   <= 1'b1;
            s1_a     <= InA;
            s1_b     <= InB;
            s1_first <= eff_first;
            s1_last  <= end_pkt;
`ifdef MPADD_SUB_EN
            s1_cin   <= InCarry | InSub;
`else
            s1_cin   <= InCarry;
`endif
        end else if (adv1) begin
            s1_vld   <= 1'b0;
        end
    end

    // Stage 2: result capture; the carry chain moves only when a word leaves stage 1
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            OutValid <= 1'b0;
            OutSum   <= '0;
            OutFirst <= 1'b0;
            OutLast  <= 1'b0;
            OutCarry <= 1'b0;
            c_reg    <= 1'b0;
        end else if (adv1) begin
            OutValid <= 1'b1;
            OutSum   <= AdderSum;
            OutFirst <= s1_first;
            OutLast  <= s1_last;
            OutCarry <= AdderCout & s1_last;
            c_reg    <= AdderCout;
        end else if (OutValid && OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Directed bench for mp_add_sequencer at DATA_WID=8, MAX_WORDS=4 with a behavioural adder attached.
module tb_mp_add_sequencer;

    localparam int DW = 8;
    localparam int MW = 4;

    logic          Clock;
    logic          Reset_n;
    logic          InValid;
    logic          InReady;
    logic [DW-1:0] InA;
    logic [DW-1:0] InB;
    logic          InFirst;
    logic          InLast;
    logic          InCarry;
`ifdef MPADD_SUB_EN
    logic          InSub;
`endif
    logic [DW-1:0] AdderA;
    logic [DW-1:0] AdderB;
    logic          AdderCin;
    logic [DW-1:0] AdderSum;
    logic          AdderCout;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutSum;
    logic          OutFirst;
    logic          OutLast;
    logic          OutCarry;
    logic          ErrOverrun;

    logic [DW:0]   add_full;

    int errors = 0;
    int checks = 0;

    mp_add_sequencer #(.DATA_WID(DW), .MAX_WORDS(MW)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .InValid(InValid), .InReady(InReady), .InA(InA), .InB(InB),
        .InFirst(InFirst), .InLast(InLast), .InCarry(InCarry),
`ifdef MPADD_SUB_EN
        .InSub(InSub),
`endif
        .AdderA(AdderA), .AdderB(AdderB), .AdderCin(AdderCin),
        .AdderSum(AdderSum), .AdderCout(AdderCout),
        .OutValid(OutValid), .OutReady(OutReady), .OutSum(OutSum),
        .OutFirst(OutFirst), .OutLast(OutLast), .OutCarry(OutCarry),
        .ErrOverrun(ErrOverrun)
    );

    assign add_full  = {1'b0, AdderA} + {1'b0, AdderB} + {{DW{1'b0}}, AdderCin};
    assign AdderSum  = add_full[DW-1:0];
    assign AdderCout = add_full[DW];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk8(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic first, input logic last, input logic cin);
        InValid = 1'b1;
        InA     = a;
        InB     = b;
        InFirst = first;
        InLast  = last;
        InCarry = cin;
    endtask

    task automatic idle();
        InValid = 1'b0;
        InFirst = 1'b0;
        InLast  = 1'b0;
    endtask

    initial begin
        Reset_n  = 1'b0;
        InValid  = 1'b0;
        InA      = '0;
        InB      = '0;
        InFirst  = 1'b0;
        InLast   = 1'b0;
        InCarry  = 1'b0;
        OutReady = 1'b1;
`ifdef MPADD_SUB_EN
        InSub    = 1'b0;
`endif
        #2;
        chk1("rst_outvalid", OutValid, 1'b0);
        chk1("rst_inready", InReady, 1'b1);
        chk8("rst_addera", AdderA, 8'h00);
        chk8("rst_adderb", AdderB, 8'h00);
        chk1("rst_addercin", AdderCin, 1'b0);
        chk8("rst_outsum", OutSum, 8'h00);
        chk1("rst_outlast", OutLast, 1'b0);
        chk1("rst_outcarry", OutCarry, 1'b0);
        chk1("rst_errov", ErrOverrun, 1'b0);
        #20;
        Reset_n = 1'b1;
        tick();

        // two-word packet {FF,01}+{01,00}
        beat(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
        tick();
        chk1("t1_lat_not_yet", OutValid, 1'b0);
        beat(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        chk1("t1_w0_valid", OutValid, 1'b1);
        chk8("t1_w0_sum", OutSum, 8'h00);
        chk1("t1_w0_first", OutFirst, 1'b1);
        chk1("t1_w0_last", OutLast, 1'b0);
        chk1("t1_w0_carry", OutCarry, 1'b0);
        idle();
        tick();
        chk1("t1_w1_valid", OutValid, 1'b1);
        chk8("t1_w1_sum", OutSum, 8'h02);
        chk1("t1_w1_first", OutFirst, 1'b0);
        chk1("t1_w1_last", OutLast, 1'b1);
        chk1("t1_w1_carry", OutCarry, 1'b0);
        tick();
        chk1("t1_drained", OutValid, 1'b0);

        // single word with packet carry-in
        beat(8'hFF, 8'h00, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        chk1("t2_valid", OutValid, 1'b1);
        chk8("t2_sum", OutSum, 8'h00);
        chk1("t2_first", OutFirst, 1'b1);
        chk1("t2_last", OutLast, 1'b1);
        chk1("t2_carry", OutCarry, 1'b1);
        tick();

        // four-word packet with a three-cycle downstream stall
        beat(8'hF0, 8'h20, 1'b1, 1'b0, 1'b0);
        tick();
        beat(8'h05, 8'hFF, 1'b0, 1'b0, 1'b0);
        tick();
        chk8("t3_w0_sum", OutSum, 8'h10);
        chk1("t3_w0_first", OutFirst, 1'b1);
        OutReady = 1'b0;
        beat(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
        #1;
        chk1("t3_inready_low", InReady, 1'b0);
        tick();
        chk1("t3_hold_valid", OutValid, 1'b1);
        chk8("t3_hold_sum1", OutSum, 8'h10);
        chk1("t3_inready_low2", InReady, 1'b0);
        tick();
        chk8("t3_hold_sum2", OutSum, 8'h10);
        tick();
        OutReady = 1'b1;
        #1;
        chk1("t3_inready_back", InReady, 1'b1);
        tick();
        chk8("t3_w1_sum", OutSum, 8'h05);
        chk1("t3_w1_first", OutFirst, 1'b0);
        beat(8'h81, 8'h90, 1'b0, 1'b1, 1'b0);
        tick();
        chk8("t3_w2_sum", OutSum, 8'h47);
        chk1("t3_w2_last", OutLast, 1'b0);
        idle();
        tick();
        chk8("t3_w3_sum", OutSum, 8'h11);
        chk1("t3_w3_last", OutLast, 1'b1);
        chk1("t3_w3_carry", OutCarry, 1'b1);
        tick();
        chk1("t3_drained", OutValid, 1'b0);

        // five beats without InLast: overrun at the fourth
        beat(8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
        tick();
        beat(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
        tick();
        chk8("t4_b0_sum", OutSum, 8'h01);
        chk1("t4_b0_first", OutFirst, 1'b1);
        tick();
        chk8("t4_b1_sum", OutSum, 8'h01);
        chk1("t4_b1_first", OutFirst, 1'b0);
        chk1("t4_no_err_yet", ErrOverrun, 1'b0);
        tick();
        chk1("t4_err_pulse", ErrOverrun, 1'b1);
        chk8("t4_b2_sum", OutSum, 8'h01);
        chk1("t4_b2_last", OutLast, 1'b0);
        beat(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        tick();
        chk1("t4_err_cleared", ErrOverrun, 1'b0);
        chk8("t4_b3_sum", OutSum, 8'h01);
        chk1("t4_b3_forced_last", OutLast, 1'b1);
        chk1("t4_b3_carry", OutCarry, 1'b1);
        idle();
        tick();
        chk8("t4_b4_sum", OutSum, 8'h00);
        chk1("t4_b4_first", OutFirst, 1'b1);
        chk1("t4_b4_last", OutLast, 1'b0);
        chk1("t4_b4_carry", OutCarry, 1'b0);
        tick();

        // reset in the middle of a three-word packet
        beat(8'h11, 8'h22, 1'b1, 1'b0, 1'b0);
        tick();
        beat(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #2;
        Reset_n = 1'b0;
        #1;
        chk1("t5_rst_outvalid", OutValid, 1'b0);
        chk8("t5_rst_outsum", OutSum, 8'h00);
        chk8("t5_rst_addera", AdderA, 8'h00);
        chk8("t5_rst_adderb", AdderB, 8'h00);
        chk1("t5_rst_addercin", AdderCin, 1'b0);
        chk1("t5_rst_first", OutFirst, 1'b0);
        chk1("t5_rst_inready", InReady, 1'b1);
        #3;
        Reset_n = 1'b1;
        tick();
        beat(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        chk1("t5_post_valid", OutValid, 1'b1);
        chk8("t5_post_sum", OutSum, 8'h30);
        chk1("t5_post_carry", OutCarry, 1'b0);
        chk1("t5_post_first", OutFirst, 1'b1);
        chk1("t5_post_last", OutLast, 1'b1);
        tick();

`ifdef MPADD_SUB_EN
        // subtract {00,00} - {01,00}
        InSub = 1'b1;
        beat(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        tick();
        InSub = 1'b0;
        beat(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        chk8("t6_w0_sum", OutSum, 8'hFF);
        idle();
        tick();
        chk8("t6_w1_sum", OutSum, 8'hFF);
        chk1("t6_w1_last", OutLast, 1'b1);
        chk1("t6_borrow", OutCarry, 1'b0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
